// File: rtl/cla_adder_pipe16_if.sv
// Operand/result handshake bundle for the two-stage 16-bit lookahead adder.
// The sub input exists only when ADD_SUB_EN is defined.
interface cla_adder_pipe16_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
`ifdef ADD_SUB_EN
    logic        sub;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        c_out;
    logic        ovf;
    logic        bp;
    logic        bg;

`ifdef ADD_SUB_EN
    modport master (output in_valid, a, b, c_in, sub, out_ready,
                    input  in_ready, out_valid, sum, c_out, ovf, bp, bg);
    modport slave  (input  in_valid, a, b, c_in, sub, out_ready,
                    output in_ready, out_valid, sum, c_out, ovf, bp, bg);
`else
    modport master (output in_valid, a, b, c_in, out_ready,
                    input  in_ready, out_valid, sum, c_out, ovf, bp, bg);
    modport slave  (input  in_valid, a, b, c_in, out_ready,
                    output in_ready, out_valid, sum, c_out, ovf, bp, bg);
`endif
endinterface

// File: rtl/cla_adder_pipe16.sv
// Two-stage pipelined 16-bit carry-lookahead adder with valid/ready on both sides.
// ADD_SUB_EN adds a sub input selecting a - b (b inverted, carry-in forced to 1).
module cla_adder_pipe16 #(
    parameter int WIDTH = 16
) (
    input logic             clk,
    input logic             rst_n,
    cla_adder_pipe16_if.slave bus
);

    // Bit carries into positions 0..3 of a 4-wide lookahead block.
    function automatic logic [3:0] lookahead4(input logic [2:0] p, input logic [2:0] g,
                                              input logic ci);
        logic [3:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    // Generate term of a 4-wide block, independent of its carry-in.
    function automatic logic group_gen(input logic [3:0] p, input logic [3:0] g);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    logic [WIDTH-1:0] b_eff_s;
    logic             cin_eff_s;
    logic [WIDTH-1:0] p_s;
    logic [WIDTH-1:0] g_s;
    logic [3:0]       bp_grp_s;
    logic [3:0]       bg_grp_s;

    logic             s1_valid_r;
    logic [WIDTH-1:0] p_r;
    logic [WIDTH-1:0] g_r;
    logic [3:0]       bp_grp_r;
    logic [3:0]       bg_grp_r;
    logic             cin_r;

    logic [3:0]       cg_s;
    logic             c16_s;
    logic             bg16_s;
    logic [WIDTH-1:0] c_bits_s;

    logic             out_valid_r;
    logic [WIDTH-1:0] sum_r;
    logic             c_out_r;
    logic             ovf_r;
    logic             bp_r;
    logic             bg_r;

    logic             s2_free_s;
    logic             adv_s;
    logic             in_ready_s;
    logic             accept_s;

    assign s2_free_s  = !out_valid_r || bus.out_ready;
    assign adv_s      = s1_valid_r && s2_free_s;
    assign in_ready_s = !s1_valid_r || s2_free_s;
    assign accept_s   = bus.in_valid && in_ready_s;

    // Stage 1 operand conditioning and per-bit / per-group propagate-generate terms.
    always_comb begin
        b_eff_s   = bus.b;
        cin_eff_s = bus.c_in;
`ifdef ADD_SUB_EN
        if (bus.sub) begin
            b_eff_s   = ~bus.b;
            cin_eff_s = 1'b1;
        end else begin
            b_eff_s   = bus.b;
            cin_eff_s = bus.c_in;
        end
`endif
        p_s = bus.a ^ b_eff_s;
        g_s = bus.a & b_eff_s;
        bp_grp_s = 4'b0000;
        bg_grp_s = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            bp_grp_s[k] = &p_s[4*k +: 4];
            bg_grp_s[k] = group_gen(p_s[4*k +: 4], g_s[4*k +: 4]);
        end
    end

    // Stage 1 register: loads on accept, empties when its contents advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            p_r        <= {WIDTH{1'b0}};
            g_r        <= {WIDTH{1'b0}};
            bp_grp_r   <= 4'b0000;
            bg_grp_r   <= 4'b0000;
            cin_r      <= 1'b0;
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            p_r        <= p_s;
            g_r        <= g_s;
            bp_grp_r   <= bp_grp_s;
            bg_grp_r   <= bg_grp_s;
            cin_r      <= cin_eff_s;
        end else if (adv_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 2 second-level lookahead: group carries are flat, then bit carries per group.
    always_comb begin
        cg_s     = lookahead4(bp_grp_r[2:0], bg_grp_r[2:0], cin_r);
        bg16_s   = group_gen(bp_grp_r, bg_grp_r);
        c16_s    = bg16_s | ((&bp_grp_r) & cin_r);
        c_bits_s = {WIDTH{1'b0}};
        for (int k = 0; k < 4; k++) begin
            c_bits_s[4*k +: 4] = lookahead4(p_r[4*k +: 3], g_r[4*k +: 3], cg_s[k]);
        end
    end

    // Stage 2 result register: result is held untouched while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            sum_r       <= {WIDTH{1'b0}};
            c_out_r     <= 1'b0;
            ovf_r       <= 1'b0;
            bp_r        <= 1'b0;
            bg_r        <= 1'b0;
        end else if (adv_s) begin
            out_valid_r <= 1'b1;
            sum_r       <= p_r ^ c_bits_s;
            c_out_r     <= c16_s;
            ovf_r       <= c_bits_s[WIDTH-1] ^ c16_s;
            bp_r        <= &p_r;
            bg_r        <= bg16_s;
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = sum_r;
    assign bus.c_out     = c_out_r;
    assign bus.ovf       = ovf_r;
    assign bus.bp        = bp_r;
    assign bus.bg        = bg_r;

endmodule
